rf_mp_scoreboard: RTL and testbench
===================================

// Module: rf_mp_scoreboard
// PURPOSE
//   Parametrised multi-port general-purpose register file for the LoongArch32 core.
//   Successor to the 3-read/1-write file: NUM_RD async read ports, NUM_WR write ports and a per-register busy scoreboard.
//   Clears storage with a post-reset sweep, one entry per cycle, so the array can map to LUTRAM.
//   Sits between decode/issue (reads, busy checks, busy set) and writeback (writes, busy clear).
// PARAMETERS
//   DATA_W  32  register width in bits
//   DEPTH   32  number of registers; power of two, >= 2
//   ADDR_W  $clog2(DEPTH)  register index width
//   NUM_RD  3   number of read ports, 1..6
//   NUM_WR  2   number of write ports, 1..4
// PORTS
//   clk        in   1              clock, all state updates on posedge
//   rst        in   1              reset rst, synchronous, active-high
//   init_done  out  1              1 = sweep finished, file usable
//   wr_en      in   NUM_WR         per-port write enable
//   wr_addr    in   NUM_WR*ADDR_W  write index; port k at [k*ADDR_W +: ADDR_W]
//   wr_data    in   NUM_WR*DATA_W  write data; port k at [k*DATA_W +: DATA_W]
//   rd_addr    in   NUM_RD*ADDR_W  read index, packed the same way
//   rd_data    out  NUM_RD*DATA_W  read data, combinational from rd_addr
//   rd_busy    out  NUM_RD         scoreboard bit of rd_addr[j], combinational
//   sb_set_en  in   1              mark sb_set_addr busy (instruction issued)
//   sb_set_addr in  ADDR_W         destination register being issued
// BEHAVIOUR
//   Reset:
//     - rst=1 on a posedge: all busy bits 0, init_done 0, sweep counter 0, state INIT.
//     - rst held high keeps the counter at 0.
//   FSM:
//     - INIT: each cycle after rst falls, storage[cnt] <= 0 and cnt++.
//     - INIT -> READY after the edge that clears entry DEPTH-1; init_done=1 from that edge (DEPTH cycles after rst falls).
//     - READY holds until rst.
//     - rst mid-sweep or in READY restarts INIT from entry 0.
//   During INIT:
//     - wr_en and sb_set_en are ignored.
//     - rd_data reads 0; rd_busy reads 0.
//   Writes (READY):
//     - On posedge, each port k with wr_en[k] and wr_addr[k]!=0 stores wr_data[k].
//     - The same edge clears busy[wr_addr[k]].
//     - Two ports writing the same address in one cycle: highest port index wins.
//   Register 0 is hardwired zero:
//     - Writes to it are dropped; rd_data for index 0 is always 0.
//     - busy[0] is never set.
//   Scoreboard:
//     - sb_set_en sets busy[sb_set_addr] on posedge.
//     - Set and clear of the same register in one cycle: set wins, because the new producer supersedes the old.
//   Reads:
//     - rd_data[j] = storage[rd_addr[j]], combinational, zero-latency.
//     - Any number of ports may read the same index.
//   Index width:
//     - ADDR_W bits exactly span DEPTH, so no out-of-range index exists.
//     - Port packing is LSB-first.
// CONFIGURATION
//   RF_BYPASS_EN defined:
//     - rd_data[j] forwards wr_data[k] combinationally when wr_en[k] and wr_addr[k]==rd_addr[j]!=0 in READY; highest k wins.
//     - rd_busy[j] reads 0 when a write to that index is in the same cycle and no same-cycle set targets it.
//   RF_BYPASS_EN undefined:
//     - rd_data and rd_busy show the pre-edge state.
//     - The written value is visible from the cycle after the write edge.
// TESTING
//   - Reset sweep: rst 1 for 2 cycles, then 0 -> init_done=0 for DEPTH(32) cycles, then 1; all rd_data=0, all rd_busy=0.
//   - Write/read: READY, port0 writes r5=32'hDEAD_BEEF -> next cycle rd_data[0..2] at addr 5 = DEAD_BEEF; a write of r0=32'h1234 -> r0 reads 0.
//   - Write conflict: port0 r7=1 and port1 r7=2 in the same cycle -> r7=2.
//   - Scoreboard: set r9 -> rd_busy=1. Set r9 and write r9 in the same cycle -> still busy. Write r9 alone -> busy 0 after the edge.
//   - Bypass:
//       - With RF_BYPASS_EN: write r3=32'hA5A5 and read r3 in the same cycle -> rd_data=A5A5 in that cycle.
//       - Without it: old value in that cycle, A5A5 in the next.
//   - Reset mid-operation: rst at sweep cnt=10, and again in READY after writes -> init_done drops, full 32-cycle sweep restarts, all registers and busy bits 0.

Source files
------------

// File: rtl/rf_mp_scoreboard.sv
// Multi-port register file with per-register busy scoreboard and post-reset clear sweep.
// Optional same-cycle write-to-read forwarding under `define RF_BYPASS_EN.
module rf_mp_scoreboard #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr
);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    r_busy;
    logic [DEPTH-1:0]    w_busy_nxt;
    logic                w_ready;
    logic                w_sweep_last;
    logic [ADDR_W-1:0]   w_wa [NUM_WR];
    logic [DATA_W-1:0]   w_wd [NUM_WR];

    assign w_ready      = (r_state == S_READY);
    assign w_sweep_last = (r_cnt == ADDR_W'(DEPTH - 1));
    assign init_done    = w_ready;

    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        assign w_wa[k] = wr_addr[k*ADDR_W +: ADDR_W];
        assign w_wd[k] = wr_data[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_INIT: begin
                if (w_sweep_last) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                w_state_nxt = S_READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // No reset on the array so it can map to LUTRAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT) begin
                r_mem[r_cnt] <= '0;
            end else begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && (w_wa[k] != '0)) begin
                        r_mem[w_wa[k]] <= w_wd[k];
                    end
                end
            end
        end
    end

    // Clears first, then the issue-side set so a new producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_ready) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k]) begin
                    w_busy_nxt[w_wa[k]] = 1'b0;
                end
            end
            if (sb_set_en) begin
                w_busy_nxt[sb_set_addr] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rdat;
        logic              w_rbusy;

        assign w_ra = rd_addr[j*ADDR_W +: ADDR_W];

`ifdef RF_BYPASS_EN
        logic w_hit;
        logic w_set_hit;

        assign w_set_hit = sb_set_en && (sb_set_addr == w_ra);

        always_comb begin
            w_hit  = 1'b0;
            w_rdat = r_mem[w_ra];
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (w_wa[k] == w_ra)) begin
                    w_hit  = 1'b1;
                    w_rdat = w_wd[k];
                end
            end
        end

        assign w_rbusy = r_busy[w_ra] & ~(w_hit & ~w_set_hit);
`else
        assign w_rdat  = r_mem[w_ra];
        assign w_rbusy = r_busy[w_ra];
`endif

        assign rd_data[j*DATA_W +: DATA_W] =
            (w_ready && (w_ra != '0)) ? w_rdat : '0;
        assign rd_busy[j] = w_ready & w_rbusy;
    end

endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Directed-vector bench for rf_mp_scoreboard (default 32x32, 3 read, 2 write ports).
// Tracks the RF_BYPASS_EN build through the same macro.
module tb_rf_mp_scoreboard;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [14:0] rd_addr;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_mp_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .sb_set_en  (sb_set_en),
        .sb_set_addr(sb_set_addr)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        se;
        logic [4:0]  sa;
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] ed0, ed1, ed2;
        logic [2:0]  eb;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(
        logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
        logic [4:0] wa1, logic [31:0] wd1,
        logic se, logic [4:0] sa,
        logic [4:0] ra0, logic [4:0] ra1, logic [4:0] ra2,
        logic [31:0] ed0, logic [31:0] ed1, logic [31:0] ed2,
        logic [2:0] eb);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.se = se; v.sa = sa;
        v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
        v.ed0 = ed0; v.ed1 = ed1; v.ed2 = ed2; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0,
                         input logic [31:0] wd0, input logic [4:0] wa1,
                         input logic [31:0] wd1, input logic se,
                         input logic [4:0] sa, input logic [4:0] ra0,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        wr_en       = we;
        wr_addr     = {wa1, wa0};
        wr_data     = {wd1, wd0};
        sb_set_en   = se;
        sb_set_addr = sa;
        rd_addr     = {ra2, ra1, ra0};
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
              5'd0, 5'd0, 5'd0);
    endtask

    // Called right after a negedge; counts edges until init_done rises.
    task automatic wait_init(input int start, output int n);
        n = start;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (init_done) break;
        end
    endtask

    task automatic read_one(input logic [4:0] a, input string name,
                            input logic [31:0] ed, input logic eb);
        rd_addr = {5'd0, 5'd0, a};
        #1;
        chk({name, "_data"}, rd_data[31:0], ed);
        chk({name, "_busy"}, {31'd0, rd_busy[0]}, {31'd0, eb});
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle();

        tbl[0]  = mk(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 0, 5'd0,
                     5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, 3'b000);
        tbl[1]  = mk(2'b10, 5'd0, 32'd0, 5'd0, 32'h1234, 0, 5'd0,
                     5'd5, 5'd5, 5'd5,
                     32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000);
        tbl[2]  = mk(2'b11, 5'd7, 32'd1, 5'd7, 32'd2, 0, 5'd0,
                     5'd0, 5'd5, 5'd1, 32'd0, 32'hDEAD_BEEF, 32'd0, 3'b000);
        tbl[3]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1, 5'd9,
                     5'd7, 5'd7, 5'd0, 32'd2, 32'd2, 32'd0, 3'b000);
        tbl[4]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 5'd0,
                     5'd9, 5'd9, 5'd7, 32'd0, 32'd0, 32'd2, 3'b011);
        tbl[5]  = mk(2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 1, 5'd9,
                     5'd7, 5'd5, 5'd0, 32'd2, 32'hDEAD_BEEF, 32'd0, 3'b000);
        tbl[6]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 5'd0,
                     5'd9, 5'd9, 5'd5, 32'h99, 32'h99, 32'hDEAD_BEEF,
                     3'b011);
        tbl[7]  = mk(2'b10, 5'd0, 32'd0, 5'd9, 32'hAA, 0, 5'd0,
                     5'd5, 5'd7, 5'd0, 32'hDEAD_BEEF, 32'd2, 32'd0, 3'b000);
        tbl[8]  = mk(2'b11, 5'd10, 32'h10, 5'd11, 32'h11, 1, 5'd0,
                     5'd9, 5'd9, 5'd9, 32'hAA, 32'hAA, 32'hAA, 3'b000);
        tbl[9]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1, 5'd12,
                     5'd0, 5'd10, 5'd11, 32'd0, 32'h10, 32'h11, 3'b000);
        tbl[10] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 0, 5'd0,
                     5'd12, 5'd0, 5'd11, 32'd0, 32'd0, 32'h11, 3'b001);

        // Power-on sweep, with writes and a set that must be ignored.
        @(negedge clk);
        @(negedge clk);
        rd_addr = {5'd2, 5'd1, 5'd0};
        #1;
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_busy", {29'd0, rd_busy}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        rd_addr = {5'd9, 5'd5, 5'd1};
        #1;
        chk("init_rd1", rd_data[63:32], 32'd0);
        chk("init_done_mid", {31'd0, init_done}, 32'd0);
        drive(2'b01, 5'd2, 32'hBAD, 5'd0, 32'd0, 1'b1, 5'd20,
              5'd2, 5'd20, 5'd0);
        @(negedge clk);
        idle();
        wait_init(13, n);
        chk("sweep_len", n, 32);
        read_one(5'd2, "init_wr_ignored", 32'd0, 1'b0);
        read_one(5'd20, "init_set_ignored", 32'd0, 1'b0);
        for (int a = 0; a < 32; a += 3) begin
            read_one(a[4:0], "swept_zero", 32'd0, 1'b0);
        end

        // Reset at sweep count 10 restarts the full sweep.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midsweep_init_done", {31'd0, init_done}, 32'd0);
        rst = 1'b0;
        wait_init(0, n);
        chk("midsweep_len", n, 32);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1,
                  tbl[i].wd1, tbl[i].se, tbl[i].sa,
                  tbl[i].ra0, tbl[i].ra1, tbl[i].ra2);
            #1;
            chk($sformatf("v%0d_rd0", i), rd_data[31:0], tbl[i].ed0);
            chk($sformatf("v%0d_rd1", i), rd_data[63:32], tbl[i].ed1);
            chk($sformatf("v%0d_rd2", i), rd_data[95:64], tbl[i].ed2);
            chk($sformatf("v%0d_busy", i), {29'd0, rd_busy},
                {29'd0, tbl[i].eb});
            @(negedge clk);
        end

        // Same-cycle write and read of r3, which is busy beforehand.
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3,
              5'd3, 5'd0, 5'd0);
        @(negedge clk);
        drive(2'b01, 5'd3, 32'hA5A5, 5'd0, 32'd0, 1'b0, 5'd0,
              5'd3, 5'd0, 5'd0);
        #1;
        chk("byp_same_data", rd_data[31:0], BYP ? 32'hA5A5 : 32'd0);
        chk("byp_same_busy", {31'd0, rd_busy[0]}, BYP ? 32'd0 : 32'd1);
        @(negedge clk);
        idle();
        read_one(5'd3, "byp_next", 32'hA5A5, 1'b0);

        // Reset in READY clears contents and busy bits.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_rst_init_done", {31'd0, init_done}, 32'd0);
        rst = 1'b0;
        wait_init(0, n);
        chk("ready_rst_len", n, 32);
        read_one(5'd5, "post_rst_r5", 32'd0, 1'b0);
        read_one(5'd9, "post_rst_r9", 32'd0, 1'b0);
        read_one(5'd12, "post_rst_r12", 32'd0, 1'b0);
        read_one(5'd3, "post_rst_r3", 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
